// File: rtl/rom_burst_arbiter.sv
// rtl/rom_burst_arbiter.sv - round-robin burst arbiter in front of a shared synchronous-read ROM
module rom_burst_arbiter #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 4,
    parameter int LEN_WIDTH   = 8,
    parameter int ROM_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   base_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    burst_len,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              rd_valid,
    output logic [NUM_REQ-1:0]              rd_last,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [ADDR_WIDTH-1:0]           rom_addr,
    input  logic [DATA_WIDTH-1:0]           rom_rd_data,
    output logic                            busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    logic [NUM_REQ-1:0]      r_gnt;
    logic                    r_busy;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LEN_WIDTH-1:0]    r_len;
    logic [LEN_WIDTH-1:0]    r_cnt;
    logic [IDX_W-1:0]        r_last_winner;

    // Tracking pipeline carries owner-one-hot valid and last so the outputs need no decode.
    logic [NUM_REQ-1:0]      r_pipe_valid [ROM_LATENCY];
    logic [NUM_REQ-1:0]      r_pipe_last  [ROM_LATENCY];

    logic                    w_found;
    logic [IDX_W-1:0]        w_sel;
    logic [ADDR_WIDTH-1:0]   w_win_base;
    logic [LEN_WIDTH-1:0]    w_win_len;
    logic                    w_issue_last;
    logic [NUM_REQ-1:0]      w_issue_valid;
    logic [NUM_REQ-1:0]      w_issue_lastv;

    // Round-robin search starting just above the previous winner.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_sel   = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(r_last_winner) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        w_win_base = '0;
        w_win_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_win_base = base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_win_len  = burst_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    assign w_issue_last  = (r_cnt == r_len);
    assign w_issue_valid = (r_state == S_ISSUE) ? r_gnt : '0;
    assign w_issue_lastv = ((r_state == S_ISSUE) && w_issue_last) ? r_gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_gnt         <= '0;
            r_busy        <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_last_winner <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt         <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
                        r_busy        <= 1'b1;
                        r_addr        <= w_win_base;
                        r_len         <= w_win_len;
                        r_cnt         <= '0;
                        r_last_winner <= w_sel;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // rom_addr stays on the final word through DRAIN.
                    if (w_issue_last) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                        r_cnt  <= r_cnt + LEN_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    if (|rd_last) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_pipe_valid[i] <= '0;
                r_pipe_last[i]  <= '0;
            end
        end else begin
            r_pipe_valid[0] <= w_issue_valid;
            r_pipe_last[0]  <= w_issue_lastv;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_last[i]  <= r_pipe_last[i-1];
            end
        end
    end

    assign gnt      = r_gnt;
    assign busy     = r_busy;
    assign rom_addr = r_addr;
    assign rd_valid = r_pipe_valid[ROM_LATENCY-1];
    assign rd_last  = r_pipe_last[ROM_LATENCY-1];
    assign rd_data  = rom_rd_data;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb/tb_rom_burst_arbiter.sv - directed self-checking bench for rom_burst_arbiter
module tb_rom_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  req;
    logic [39:0] base_bus;
    logic [31:0] len_bus;
    logic [3:0]  gnt, rd_valid, rd_last;
    logic [31:0] rd_data, rom_q2;
    logic [9:0]  rom_addr, rom_a_q;
    logic        busy;

    logic [3:0]  req1;
    logic [39:0] base_bus1;
    logic [31:0] len_bus1;
    logic [3:0]  gnt1, rv1, rl1;
    logic [31:0] rd1, rom_q1;
    logic [9:0]  ra1;
    logic        busy1;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    rom_burst_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_REQ(4), .LEN_WIDTH(8), .ROM_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .base_addr(base_bus), .burst_len(len_bus),
        .gnt(gnt), .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data),
        .rom_addr(rom_addr), .rom_rd_data(rom_q2), .busy(busy)
    );

    rom_burst_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .NUM_REQ(4), .LEN_WIDTH(8), .ROM_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .base_addr(base_bus1), .burst_len(len_bus1),
        .gnt(gnt1), .rd_valid(rv1), .rd_last(rl1), .rd_data(rd1),
        .rom_addr(ra1), .rom_rd_data(rom_q1), .busy(busy1)
    );

    function automatic logic [31:0] rom_f(input logic [9:0] a);
        return {a, 12'h5A5, a};
    endfunction

    always @(posedge clk) begin
        rom_a_q <= rom_addr;
        rom_q2  <= rom_f(rom_a_q);
        rom_q1  <= rom_f(ra1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        req1  = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    // Expects the grant edge to be the next clock edge; checks every cycle of a ROM_LATENCY=2 burst.
    task automatic burst2(input logic [3:0] who, input logic [9:0] base, input int n,
                          input logic [3:0] drop_mask, input int drop_at);
        logic [9:0] a;
        for (int c = 0; c < n + 2; c++) begin
            step();
            if (c == drop_at) req = req & ~drop_mask;
            chk("gnt", 32'(gnt), 32'(who));
            chk("busy", 32'(busy), 32'd1);
            a = (c < n) ? base + 10'(c) : base + 10'(n - 1);
            chk("rom_addr", 32'(rom_addr), 32'(a));
            if (c >= 2) begin
                a = base + 10'(c - 2);
                chk("rd_valid", 32'(rd_valid), 32'(who));
                chk("rd_data", rd_data, rom_f(a));
                chk("rd_last", 32'(rd_last), (c == n + 1) ? 32'(who) : 32'd0);
            end else begin
                chk("rd_valid_early", 32'(rd_valid), 32'd0);
                chk("rd_last_early", 32'(rd_last), 32'd0);
            end
        end
        step();
        chk("gnt_idle", 32'(gnt), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("rd_valid_idle", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        base_bus  = '0;
        len_bus   = '0;
        req1      = '0;
        base_bus1 = '0;
        len_bus1  = '0;
        step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_last", 32'(rd_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        do_reset();

        // single burst on requester 1
        base_bus[10 +: 10] = 10'h010;
        len_bus[8 +: 8]    = 8'd3;
        req = 4'b0010;
        burst2(4'b0010, 10'h010, 4, 4'b0010, 5);

        // req dropped right after grant still yields all 8 words
        base_bus[10 +: 10] = 10'h100;
        len_bus[8 +: 8]    = 8'd7;
        req = 4'b0010;
        burst2(4'b0010, 10'h100, 8, 4'b0010, 0);

        // address wrap
        base_bus[0 +: 10] = 10'h3FE;
        len_bus[0 +: 8]   = 8'd3;
        req = 4'b0001;
        burst2(4'b0001, 10'h3FE, 4, 4'b0001, 5);

        // priority after reset: 1 then 3
        do_reset();
        base_bus[10 +: 10] = 10'h050;
        len_bus[8 +: 8]    = 8'd0;
        base_bus[30 +: 10] = 10'h070;
        len_bus[24 +: 8]   = 8'd1;
        req = 4'b1010;
        burst2(4'b0010, 10'h050, 1, 4'b0010, 2);
        burst2(4'b1000, 10'h070, 2, 4'b1000, 3);

        // round-robin fairness with all requests held
        do_reset();
        len_bus  = '0;
        base_bus = {10'h080, 10'h060, 10'h040, 10'h020};
        req = 4'b1111;
        burst2(4'b0001, 10'h020, 1, 4'b0000, -1);
        burst2(4'b0010, 10'h040, 1, 4'b0000, -1);
        burst2(4'b0100, 10'h060, 1, 4'b0000, -1);
        burst2(4'b1000, 10'h080, 1, 4'b0000, -1);
        burst2(4'b0001, 10'h020, 1, 4'b1111, 2);

        // reset asserted during ISSUE
        base_bus[20 +: 10] = 10'h200;
        len_bus[16 +: 8]   = 8'd7;
        req = 4'b0100;
        step();
        chk("mr_gnt", 32'(gnt), 32'b0100);
        step();
        chk("mr_addr", 32'(rom_addr), 32'h201);
        #2;
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk("mr_async_gnt", 32'(gnt), 32'd0);
        chk("mr_async_busy", 32'(busy), 32'd0);
        chk("mr_async_addr", 32'(rom_addr), 32'd0);
        chk("mr_async_rv", 32'(rd_valid), 32'd0);
        chk("mr_async_rl", 32'(rd_last), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_no_stale_rv", 32'(rd_valid), 32'd0);
            chk("mr_no_stale_gnt", 32'(gnt), 32'd0);
        end
        req = 4'b0100;
        burst2(4'b0100, 10'h200, 8, 4'b0100, 9);

        // ROM_LATENCY=1 instance
        base_bus1[0 +: 10] = 10'h005;
        len_bus1[0 +: 8]   = 8'd1;
        req1 = 4'b0001;
        step();
        req1 = 4'b0000;
        chk("l1_gnt0", 32'(gnt1), 32'b0001);
        chk("l1_addr0", 32'(ra1), 32'h005);
        chk("l1_rv0", 32'(rv1), 32'd0);
        step();
        chk("l1_gnt1", 32'(gnt1), 32'b0001);
        chk("l1_addr1", 32'(ra1), 32'h006);
        chk("l1_rv1", 32'(rv1), 32'b0001);
        chk("l1_rl1", 32'(rl1), 32'd0);
        chk("l1_data1", rd1, rom_f(10'h005));
        step();
        chk("l1_gnt2", 32'(gnt1), 32'b0001);
        chk("l1_addr2", 32'(ra1), 32'h006);
        chk("l1_rv2", 32'(rv1), 32'b0001);
        chk("l1_rl2", 32'(rl1), 32'b0001);
        chk("l1_data2", rd1, rom_f(10'h006));
        step();
        chk("l1_gnt3", 32'(gnt1), 32'd0);
        chk("l1_busy3", 32'(busy1), 32'd0);
        chk("l1_rv3", 32'(rv1), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_burst_arbiter.md
Name: rom_burst_arbiter

Overview:
- Shares one single-port coefficient/window ROM (synchronous read, fixed read latency) between NUM_REQ audio datapath requesters, for example FIR, window and gain stages.
- Each requester asks for a burst of consecutive words. The block arbitrates round-robin, issues one ROM address per cycle, and returns the data tagged with a per-requester valid and last strobe.
- Sits directly in front of the ROM macro, whose clk_en is tied high.

Parameters:
- ADDR_WIDTH, 10: ROM address width.
- DATA_WIDTH, 32: ROM data width.
- NUM_REQ, 4: number of requesters, 2..8.
- LEN_WIDTH, 8: burst length field width. Words per burst = burst_len+1.
- ROM_LATENCY, 2: cycles from rom_addr to valid rom_rd_data. Legal values 1 and 2 (ROM output register off/on).

Ports:
- clk, input, 1: single clock for the block and the ROM.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, NUM_REQ: burst request per requester. Level; hold until own rd_last.
- base_addr, input, NUM_REQ*ADDR_WIDTH: per-requester start address; slice i belongs to requester i.
- burst_len, input, NUM_REQ*LEN_WIDTH: per-requester length minus one.
- gnt, output, NUM_REQ: one-hot. High while the requester's burst is in flight.
- rd_valid, output, NUM_REQ: one-hot. Returned word belongs to requester i.
- rd_last, output, NUM_REQ: one-hot. Final word of the burst; same cycle as the corresponding rd_valid.
- rd_data, output, DATA_WIDTH: returned word. Meaningful only when any rd_valid bit is high.
- rom_addr, output, ADDR_WIDTH: to ROM addr.
- rom_rd_data, input, DATA_WIDTH: from ROM rd_data.
- busy, output, 1: FSM not in IDLE.

Behaviour:
- Reset (async assert, release on clk edge): FSM=IDLE. gnt, rd_valid, rd_last, busy, rom_addr all 0. Round-robin pointer set so requester 0 has top priority.
- FSM IDLE: req is sampled only in IDLE. If any bit is set, select the first set bit searching upward from (last_winner+1) mod NUM_REQ, wrapping. On that edge:
  - latch base_addr and burst_len of the winner;
  - set gnt one-hot and busy=1;
  - go to ISSUE.
- FSM ISSUE: rom_addr = current address every cycle.
  - Address increments by 1 mod 2^ADDR_WIDTH; wrap from max to 0 is legal and silent.
  - Word counter counts burst_len+1 issues, then go to DRAIN.
  - The first address appears in the cycle gnt first reads high.
- FSM DRAIN: no new addresses; rom_addr holds the last issued value.
  - Wait until the issue-tracking pipeline is empty.
  - The edge after the cycle carrying rd_last: gnt=0, busy=0, FSM→IDLE.
- Tracking pipeline:
  - ROM_LATENCY-deep shift register of {valid, last, owner}.
  - rd_valid/rd_last are its registered outputs.
  - rd_data = rom_rd_data, passed through combinationally.
  - rd_valid for the address issued in cycle t appears in cycle t+ROM_LATENCY.
- Throughput and timing:
  - One word per cycle within a burst.
  - burst_len=0 gives a single word with rd_valid and rd_last together.
  - Gap between consecutive bursts: the FSM sits in IDLE for exactly one cycle.
  - Total for N words: gnt high for N+ROM_LATENCY cycles.
- Input changes:
  - req deassertion mid-burst is ignored; the burst completes.
  - base_addr/burst_len changes after the grant edge have no effect.
- Simultaneous requests in IDLE: only one winner; the others wait. last_winner updates at grant.
- Reset mid-burst: all state cleared immediately. No further rd_valid; in-flight ROM data is discarded.
- Invariants:
  - gnt, rd_valid and rd_last are never multi-hot.
  - rd_valid is only ever high for the currently granted requester.

Test Plan:
1. Single burst, ROM_LATENCY=2: req[1]=1, base=0x010, len=3 → gnt=0010 next edge. rom_addr 0x010..0x013 on 4 consecutive cycles. rd_valid[1] on 4 cycles starting 2 cycles after the first address, with rd_data = ROM[0x010..0x013]. rd_last[1] with word 0x013. gnt low after 6 cycles; busy cleared.
2. Round-robin fairness: req=1111 held, each len=0 → grants in order 0,1,2,3,0. Each burst is 1 word with rd_valid and rd_last coincident. One IDLE cycle between bursts.
3. Address wrap: base=0x3FE, len=3, ADDR_WIDTH=10 → rom_addr 0x3FE, 0x3FF, 0x000, 0x001. 4 valids returned, last on word 0x001.
4. ROM_LATENCY=1 build: base=0x005, len=1 → rd_valid 1 cycle after each address. gnt high 3 cycles total.
5. Mid-burst events:
   - req dropped after grant (len=7) → all 8 words still returned.
   - rst_n pulsed low during ISSUE → all outputs 0 asynchronously; after release, req[2] alone is granted normally.
6. Priority after reset: req=1010 raised simultaneously → requester 1 wins first, then 3. rd_valid never asserted for a non-granted requester.
